v810_ifq: RTL and testbench

Instruction prefetch queue for the V810 core. It sits between the memory unit's instruction-fetch port and the execution unit. It issues word-aligned 32-bit fetches and buffers the results as halfwords. It presents the next one or two halfwords at the current PC so the exec unit can consume 16- or 32-bit instructions. It also handles branch flushes, including a fetch that is still in flight when the flush arrives.

---
 rtl/v810_ifq.sv | 223 ++++++++++++++++++++++
 tb/tb_v810_ifq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/v810_ifq.sv
// ----------------------------------------------------------------------------
// v810_ifq -- instruction prefetch queue for the V810 core.
//
// Issues word-aligned 32-bit fetches to the memory unit and buffers the
// returned data as halfwords in a circular buffer. The exec unit sees the
// next one or two halfwords at the current PC and consumes 0, 1 or 2 of them
// per cycle. Branch flushes redirect the queue, including the case where a
// fetch is still outstanding (that fetch is completed and its data dropped).
//
// Build option:
//   V810_IFQ_BYPASS_EN  when defined, a fetch returning into an empty queue
//                       is forwarded combinationally to Q_D/Q_AVAIL in the
//                       same cycle. Undefined: fixed one-cycle latency.
//
// Parameters:
//   DEPTH      queue capacity in halfwords (power of two, >= 4)
//
// Ports:
//   CLK        clock
//   RES        synchronous active-high reset
//   CE         global clock enable; nothing advances while low
//   IA         fetch address (word aligned), stable while IREQ is high
//   ID         fetch data, valid on the IACK cycle
//   IREQ       fetch request
//   IACK       one-cycle fetch acknowledge
//   FLUSH      redirect the queue to FLUSH_PC
//   FLUSH_PC   new PC (bit 0 ignored)
//   Q_PC       address of the head halfword
//   Q_D        head halfword in [15:0], next halfword in [31:16]
//   Q_AVAIL    number of valid halfwords presented, min(count, 2)
//   POP        halfwords consumed this cycle (clamped to Q_AVAIL)
//   dbg_state  fetch FSM state (0 idle, 1 request, 2 drop)
//
// Handshakes:
//   Fetch port: IREQ is a request that, once raised, is held with IA
//   unchanged until the cycle IACK is seen (with CE high); the data on ID is
//   taken on that cycle. Queue port: Q_AVAIL is the "valid" count; POP is the
//   consumer's take, effective at the clock edge, and any POP beyond Q_AVAIL
//   is ignored. All handshake events only count in CE cycles.
// ----------------------------------------------------------------------------
module v810_ifq #(
  parameter int DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  output logic [31:0] IA,
  input  logic [31:0] ID,
  output logic        IREQ,
  input  logic        IACK,
  input  logic        FLUSH,
  input  logic [31:0] FLUSH_PC,
  output logic [31:0] Q_PC,
  output logic [31:0] Q_D,
  output logic [1:0]  Q_AVAIL,
  input  logic [1:0]  POP,
  output logic [1:0]  dbg_state
);

  localparam int PW = $clog2(DEPTH);
  // Refill threshold: a full word can be accepted only with two free slots.
  localparam logic [PW:0] REFILL_LIMIT = (PW+1)'(DEPTH - 2);
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } fsm_t;

  fsm_t          state;
  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic          skip;
  logic [31:0]   q_pc;
  logic [31:0]   ia;
  logic [31:0]   pend_ia;

  // Combinational helpers
  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;
  logic          fetch_live;   // non-stale fetch completing this cycle
  logic [1:0]    push_n;       // halfwords pushed this cycle
  logic [1:0]    buf_avail;
  logic [31:0]   buf_d;
  logic [1:0]    view_avail;   // what the exec unit sees (buffer or bypass)
  logic [31:0]   view_d;
  logic [1:0]    pop_c;        // POP clamped to what is presented
  logic [PW:0]   count_nxt;
  logic [31:0]   flush_pc_hw;
  logic [31:0]   flush_ia;
  logic          unused_fpc0;

  assign head_p1     = head + 1'b1;
  assign tail_p1     = tail + 1'b1;
  assign flush_pc_hw = {FLUSH_PC[31:1], 1'b0};
  assign flush_ia    = {FLUSH_PC[31:2], 2'b00};
  assign unused_fpc0 = FLUSH_PC[0];

  assign fetch_live  = (state == S_REQ) && IACK;

  always_comb begin
    push_n = 2'd0;
    if (fetch_live) begin
      // After a flush to an odd halfword, the low half of the first word
      // precedes the new PC and is dropped.
      push_n = skip ? 2'd1 : 2'd2;
    end
  end

  // Buffered view of the head of the queue.
  always_comb begin
    buf_avail = 2'd0;
    buf_d     = 32'h0;
    if (count >= (PW+1)'(2)) begin
      buf_avail = 2'd2;
      buf_d     = {mem[head_p1], mem[head]};
    end else if (count == (PW+1)'(1)) begin
      buf_avail = 2'd1;
      buf_d     = {16'h0, mem[head]};
    end
  end

  // Presented view: normally the buffer; with bypass enabled, a fetch
  // landing in an empty queue is shown directly. Gated by CE so the outputs
  // stay frozen while the block is stalled.
  always_comb begin
    view_avail = buf_avail;
    view_d     = buf_d;
`ifdef V810_IFQ_BYPASS_EN
    if (CE && !RES && !FLUSH && fetch_live && (count == '0)) begin
      view_avail = push_n;
      view_d     = skip ? {16'h0, ID[31:16]} : ID;
    end
`endif
  end

  assign pop_c = (POP > view_avail) ? view_avail : POP;

  // Pushing everything and advancing head by the pop amount is equivalent
  // to writing only the unconsumed halfwords when bypass consumes data.
  assign count_nxt = count + (PW+1)'(push_n) - (PW+1)'(pop_c);

  // Halfword storage. No reset needed: entries are only presented when
  // counted valid.
  always_ff @(posedge CLK) begin
    if (CE && !RES && !FLUSH && fetch_live) begin
      if (skip) begin
        mem[tail] <= ID[31:16];
      end else begin
        mem[tail]    <= ID[15:0];
        mem[tail_p1] <= ID[31:16];
      end
    end
  end

  // Pointers, PC tracking and fetch FSM.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state   <= S_IDLE;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      skip    <= 1'b0;
      q_pc    <= RESET_PC;
      ia      <= RESET_PC;
      pend_ia <= RESET_PC;
    end else if (CE) begin
      if (FLUSH) begin
        // Flush wins over POP and IACK; same-cycle fetch data is discarded.
        head  <= '0;
        tail  <= '0;
        count <= '0;
        q_pc  <= flush_pc_hw;
        skip  <= FLUSH_PC[1];
        if ((state == S_IDLE) || IACK) begin
          // No request left outstanding: start the new fetch right away.
          ia    <= flush_ia;
          state <= S_REQ;
        end else begin
          // A request is still outstanding and IA must not move until it
          // is acknowledged; park the new address.
          pend_ia <= flush_ia;
          state   <= S_DROP;
        end
      end else begin
        head  <= head + PW'(pop_c);
        tail  <= tail + PW'(push_n);
        count <= count_nxt;
        q_pc  <= q_pc + {29'h0, pop_c, 1'b0};
        case (state)
          S_IDLE: begin
            if (count_nxt <= REFILL_LIMIT) state <= S_REQ;
          end
          S_REQ: begin
            if (IACK) begin
              ia    <= ia + 32'd4;
              skip  <= 1'b0;
              state <= S_IDLE;
            end
          end
          S_DROP: begin
            if (IACK) begin
              ia    <= pend_ia;
              state <= S_REQ;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign IREQ      = (state != S_IDLE);
  assign IA        = ia;
  assign Q_PC      = q_pc;
  assign Q_D       = view_d;
  assign Q_AVAIL   = view_avail;
  assign dbg_state = state;

endmodule

// File: tb/tb_v810_ifq.sv
// ----------------------------------------------------------------------------
// tb_v810_ifq -- self-checking bench for v810_ifq.
// Directed scenarios followed by randomized traffic, checked every cycle
// against a halfword-queue reference model of the prefetch queue.
// ----------------------------------------------------------------------------
module tb_v810_ifq;
  localparam int DEPTH = 8;

  // Clock / reset / DUT
  logic        CLK = 1'b0;
  logic        RES;
  logic        CE;
  logic [31:0] IA;
  logic [31:0] ID;
  logic        IREQ;
  logic        IACK;
  logic        FLUSH;
  logic [31:0] FLUSH_PC;
  logic [31:0] Q_PC;
  logic [31:0] Q_D;
  logic [1:0]  Q_AVAIL;
  logic [1:0]  POP;
  logic [1:0]  dbg_state;

  always #5 CLK = ~CLK;

  v810_ifq #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RES(RES), .CE(CE), .IA(IA), .ID(ID), .IREQ(IREQ),
    .IACK(IACK), .FLUSH(FLUSH), .FLUSH_PC(FLUSH_PC), .Q_PC(Q_PC),
    .Q_D(Q_D), .Q_AVAIL(Q_AVAIL), .POP(POP), .dbg_state(dbg_state)
  );

  // Scoreboard / reference model
  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];      // halfwords in the queue, head first
  logic [31:0] m_qpc;
  logic [31:0] m_ia;
  logic [31:0] m_pend;
  logic        m_skip;
  logic        m_busy;        // a fetch request is outstanding
  logic        m_stale;       // the outstanding fetch belongs to a flushed stream

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_qpc   = 32'hFFFF_FFF0;
    m_ia    = 32'hFFFF_FFF0;
    m_pend  = 32'h0;
    m_skip  = 1'b0;
    m_busy  = 1'b0;
    m_stale = 1'b0;
  endtask

  // Driver helpers
  task automatic clr_in();
    RES = 1'b0; CE = 1'b1; IACK = 1'b0; FLUSH = 1'b0;
    FLUSH_PC = 32'h0; POP = 2'd0; ID = 32'h0;
  endtask

  // One clock cycle: inputs are already driven (after a negedge). Check the
  // outputs against the model, take the edge, advance the model.
  task automatic cyc();
    logic [15:0] inc[$];
    logic [15:0] v[$];
    logic        byp;
    int          av;
    int          p;
    logic [31:0] ed;
    inc = {};
    if (m_busy && !m_stale && IACK) begin
      if (!m_skip) inc.push_back(ID[15:0]);
      inc.push_back(ID[31:16]);
    end
    byp = 1'b0;
`ifdef V810_IFQ_BYPASS_EN
    byp = CE && !RES && !FLUSH && (exp_q.size() == 0) && (inc.size() > 0);
`endif
    if (byp) v = inc;
    else     v = exp_q;
    av = (v.size() > 2) ? 2 : v.size();
    ed = 32'h0;
    if (av > 0) ed[15:0]  = v[0];
    if (av > 1) ed[31:16] = v[1];
    #1;
    chk("ireq",    {31'h0, IREQ},    {31'h0, m_busy});
    chk("ia",      IA,               m_ia);
    chk("q_pc",    Q_PC,             m_qpc);
    chk("q_avail", {30'h0, Q_AVAIL}, 32'(av));
    chk("q_d",     Q_D,              ed);
    @(posedge CLK);
    if (RES) begin
      model_reset();
    end else if (CE) begin
      if (FLUSH) begin
        exp_q.delete();
        m_qpc  = FLUSH_PC & ~32'h1;
        m_skip = FLUSH_PC[1];
        if (!m_busy || IACK) begin
          m_ia    = FLUSH_PC & ~32'h3;
          m_busy  = 1'b1;
          m_stale = 1'b0;
        end else begin
          m_pend  = FLUSH_PC & ~32'h3;
          m_stale = 1'b1;
        end
      end else begin
        p = (int'(POP) > av) ? av : int'(POP);
        foreach (inc[i]) exp_q.push_back(inc[i]);
        repeat (p) void'(exp_q.pop_front());
        m_qpc = m_qpc + 32'(2 * p);
        if (m_busy && IACK) begin
          if (m_stale) begin
            m_ia    = m_pend;
            m_stale = 1'b0;
          end else begin
            m_ia   = m_ia + 32'd4;
            m_skip = 1'b0;
            m_busy = 1'b0;
          end
        end else if (!m_busy && exp_q.size() <= DEPTH - 2) begin
          m_busy = 1'b1;
        end
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    // Reset
    clr_in();
    RES = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    model_reset();
    #1;
    chk("rst_ireq",  {31'h0, IREQ},    32'h0);
    chk("rst_ia",    IA,               32'hFFFF_FFF0);
    chk("rst_q_pc",  Q_PC,             32'hFFFF_FFF0);
    chk("rst_avail", {30'h0, Q_AVAIL}, 32'h0);
    chk("rst_q_d",   Q_D,              32'h0);
    cyc();

    // Reset release and first fetch
    RES = 1'b0;
    cyc();
    #1;
    chk("rel_ireq", {31'h0, IREQ}, 32'h1);
    chk("rel_ia",   IA,            32'hFFFF_FFF0);
    IACK = 1'b1; ID = 32'h2222_1111;
    cyc();
    clr_in(); #1;
    chk("f1_avail", {30'h0, Q_AVAIL}, 32'h2);
    chk("f1_q_d",   Q_D,              32'h2222_1111);
    chk("f1_q_pc",  Q_PC,             32'hFFFF_FFF0);

    // Flush to an odd halfword
    FLUSH = 1'b1; FLUSH_PC = 32'h0000_1002;
    cyc();
    clr_in(); #1;
    chk("fl_ia",   IA,            32'h0000_1000);
    chk("fl_ireq", {31'h0, IREQ}, 32'h1);
    IACK = 1'b1; ID = 32'hBBBB_AAAA;
    cyc();
    clr_in(); #1;
    chk("skip_avail", {30'h0, Q_AVAIL}, 32'h1);
    chk("skip_q_d",   Q_D,              32'h0000_BBBB);
    chk("skip_q_pc",  Q_PC,             32'h0000_1002);

    // Fill to capacity with no consumption
    FLUSH = 1'b1; FLUSH_PC = 32'h0000_3000;
    cyc();
    clr_in();
    for (int i = 0; i < 10; i++) begin
      IACK = m_busy; ID = $urandom;
      cyc();
    end
    clr_in(); #1;
    chk("full_ireq", {31'h0, IREQ}, 32'h0);
    cyc();
    POP = 2'd2;
    cyc();
    clr_in(); #1;
    chk("refill_ireq", {31'h0, IREQ}, 32'h1);
    chk("refill_q_pc", Q_PC,          32'h0000_3004);

    // Flush while a fetch is outstanding
    IACK = 1'b1; ID = $urandom;
    cyc();
    clr_in();
    FLUSH = 1'b1; FLUSH_PC = 32'h0000_1004;
    cyc();
    clr_in(); #1;
    chk("pre_ia", IA, 32'h0000_1004);
    cyc();
    FLUSH = 1'b1; FLUSH_PC = 32'h0000_2000;
    cyc();
    clr_in();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("drop_ireq",  {31'h0, IREQ},    32'h1);
      chk("drop_ia",    IA,               32'h0000_1004);
      chk("drop_avail", {30'h0, Q_AVAIL}, 32'h0);
      cyc();
    end
    IACK = 1'b1; ID = $urandom;
    cyc();
    clr_in(); #1;
    chk("redir_ireq",  {31'h0, IREQ},    32'h1);
    chk("redir_ia",    IA,               32'h0000_2000);
    chk("redir_avail", {30'h0, Q_AVAIL}, 32'h0);

    // Address wrap, with a flush coinciding with IACK
    FLUSH = 1'b1; FLUSH_PC = 32'hFFFF_FFFC; IACK = 1'b1; ID = $urandom;
    cyc();
    clr_in(); #1;
    chk("wrap_ia0", IA, 32'hFFFF_FFFC);
    IACK = 1'b1; ID = $urandom;
    cyc();
    clr_in();
    cyc();
    #1;
    chk("wrap_ia1",   IA,            32'h0000_0000);
    chk("wrap_ireq1", {31'h0, IREQ}, 32'h1);
    IACK = 1'b1; ID = $urandom;
    cyc();
    clr_in();
    POP = 2'd2;
    cyc();
    cyc();
    clr_in(); #1;
    chk("wrap_q_pc", Q_PC, 32'h0000_0004);

    // Clock enable low: everything frozen
    for (int i = 0; i < 5; i++) begin
      CE = 1'b0; IACK = 1'b1; POP = 2'd2; FLUSH = i[0]; FLUSH_PC = $urandom; ID = $urandom;
      cyc();
    end
    clr_in(); #1;
    chk("ce_ia",    IA,               32'h0000_0004);
    chk("ce_ireq",  {31'h0, IREQ},    32'h1);
    chk("ce_q_pc",  Q_PC,             32'h0000_0004);
    chk("ce_avail", {30'h0, Q_AVAIL}, 32'h0);

    // Fetch into an empty queue
    IACK = 1'b1; ID = 32'h4444_3333;
`ifdef V810_IFQ_BYPASS_EN
    #1;
    chk("byp_avail", {30'h0, Q_AVAIL}, 32'h2);
    chk("byp_q_d",   Q_D,              32'h4444_3333);
`endif
    cyc();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      clr_in();
      CE       = ($urandom_range(0, 9) != 0);
      RES      = CE && ($urandom_range(0, 199) == 0);
      FLUSH    = ($urandom_range(0, 19) == 0);
      FLUSH_PC = $urandom;
      IACK     = m_busy && ($urandom_range(0, 1) == 1);
      ID       = $urandom;
      POP      = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
